// File: rtl/debug_step_controller.sv
// debug_step_controller
//   Host-driven debug controller: free-run, single-step and register-file
//   dump over a byte-wide host link.
//   Ports:
//     i_clk, i_rst         clock, synchronous active-high reset
//     i_cmd, i_cmd_valid   command byte from host ('c' run, 's' step, 'r' dump)
//     o_cmd_ready          command accepted when valid & ready (IDLE/HALTED)
//     i_halt               halt instruction retired (honoured in RUN/STEP)
//     i_dbg_reg_data       register-file read data for o_dbg_reg_sel
//     o_dbg_reg_sel        register index being dumped (0 outside dump)
//     o_step               pipeline advance enable
//     o_tx_data/valid      dump byte stream to host, MSB first
//     i_tx_ready           host link ready
//     o_cycle_count        saturating count of stepped cycles
//     o_state              current FSM state encoding
module debug_step_controller #(
  parameter int unsigned NBITS = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_cmd,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic             i_halt,
  input  logic [NBITS-1:0] i_dbg_reg_data,
  output logic [4:0]       o_dbg_reg_sel,
  output logic             o_step,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_valid,
  input  logic             i_tx_ready,
  output logic [31:0]      o_cycle_count,
  output logic [2:0]       o_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    STEP      = 3'd2,
    DUMP_LOAD = 3'd3,
    DUMP_SEND = 3'd4,
    HALTED    = 3'd5
  } state_t;

  state_t      state, nxt_state;
  state_t      ret_state, nxt_ret;
  logic [4:0]  reg_idx, nxt_reg;
  logic [1:0]  byte_idx, nxt_byte;
  logic [31:0] buffer, nxt_buffer;
  logic [31:0] load_word;
  logic [7:0]  nxt_tx_byte;
  logic        cmd_fire, tx_fire;

  assign load_word = 32'(i_dbg_reg_data);
  assign cmd_fire  = i_cmd_valid && o_cmd_ready;
  assign tx_fire   = o_tx_valid && i_tx_ready;

  always_comb begin
    nxt_state  = state;
    nxt_ret    = ret_state;
    nxt_reg    = reg_idx;
    nxt_byte   = byte_idx;
    nxt_buffer = buffer;
    case (state)
      IDLE: begin
        if (cmd_fire) begin
          case (i_cmd)
            8'h63: nxt_state = RUN;
            8'h73: nxt_state = STEP;
            8'h72: begin
              nxt_state = DUMP_LOAD;
              nxt_ret   = IDLE;
              nxt_reg   = '0;
              nxt_byte  = '0;
            end
            default: nxt_state = IDLE;
          endcase
        end
      end
      RUN:  if (i_halt) nxt_state = HALTED;
      STEP: nxt_state = i_halt ? HALTED : IDLE;
      DUMP_LOAD: begin
        nxt_buffer = load_word;
        nxt_state  = DUMP_SEND;
      end
      DUMP_SEND: begin
        if (tx_fire) begin
          nxt_byte = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            if (reg_idx != 5'd31) begin
              nxt_reg   = reg_idx + 5'd1;
              nxt_state = DUMP_LOAD;
            end else begin
              nxt_state = ret_state;
            end
          end
        end
      end
      HALTED: begin
        if (cmd_fire && i_cmd == 8'h72) begin
          nxt_state = DUMP_LOAD;
          nxt_ret   = HALTED;
          nxt_reg   = '0;
          nxt_byte  = '0;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    nxt_tx_byte = '0;
    case (nxt_byte)
      2'd0: nxt_tx_byte = nxt_buffer[31:24];
      2'd1: nxt_tx_byte = nxt_buffer[23:16];
      2'd2: nxt_tx_byte = nxt_buffer[15:8];
      2'd3: nxt_tx_byte = nxt_buffer[7:0];
      default: nxt_tx_byte = '0;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with
  // the state register while still being Moore functions of it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      ret_state     <= IDLE;
      reg_idx       <= '0;
      byte_idx      <= '0;
      buffer        <= '0;
      o_step        <= 1'b0;
      o_cmd_ready   <= 1'b1;
      o_tx_valid    <= 1'b0;
      o_tx_data     <= '0;
      o_dbg_reg_sel <= '0;
      o_cycle_count <= '0;
      o_state       <= IDLE;
    end else begin
      state         <= nxt_state;
      ret_state     <= nxt_ret;
      reg_idx       <= nxt_reg;
      byte_idx      <= nxt_byte;
      buffer        <= nxt_buffer;
      o_step        <= (nxt_state == RUN) || (nxt_state == STEP);
      o_cmd_ready   <= (nxt_state == IDLE) || (nxt_state == HALTED);
      o_tx_valid    <= (nxt_state == DUMP_SEND);
      o_tx_data     <= (nxt_state == DUMP_SEND) ? nxt_tx_byte : '0;
      o_dbg_reg_sel <= ((nxt_state == DUMP_LOAD) || (nxt_state == DUMP_SEND)) ? nxt_reg : '0;
      o_state       <= nxt_state;
      if (o_step && (o_cycle_count != '1))
        o_cycle_count <= o_cycle_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_debug_step_controller.sv
module tb_debug_step_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cmd;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        halt;
  logic [31:0] reg_data;
  logic [4:0]  reg_sel;
  logic        step;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] cycle_count;
  logic [2:0]  state;

  logic [31:0] reg_base;
  logic [7:0]  exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          bytes_seen = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;

  always #5 clk = ~clk;

  // Register file model: register k reads as reg_base + k.
  assign reg_data = reg_base + {27'd0, reg_sel};

  debug_step_controller #(.NBITS(32)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cmd         (cmd),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_halt        (halt),
    .i_dbg_reg_data(reg_data),
    .o_dbg_reg_sel (reg_sel),
    .o_step        (step),
    .o_tx_data     (tx_data),
    .o_tx_valid    (tx_valid),
    .i_tx_ready    (tx_ready),
    .o_cycle_count (cycle_count),
    .o_state       (state)
  );

  // Monitor: pops the expected byte stream on every handshake and checks
  // that a stalled byte is held.
  always @(negedge clk) begin
    if (!rst && prev_stall) begin
      checks++;
      if (!(tx_valid && tx_data == prev_data)) begin
        errors++;
        $display("FAIL tx_stable: valid=%0b data=%02h required valid=1 data=%02h",
                 tx_valid, tx_data, prev_data);
      end
    end
    if (!rst && tx_valid && tx_ready) begin
      checks++;
      bytes_seen++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_extra: data=%02h required no byte", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          errors++;
          $display("FAIL tx_byte: data=%02h required %02h (byte %0d)", tx_data, e, bytes_seen - 1);
        end
      end
    end
    prev_stall = !rst && tx_valid && !tx_ready;
    prev_data  = tx_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] c);
    cmd       = c;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd       = '0;
  endtask

  task automatic push_dump(input logic [31:0] base);
    logic [31:0] w;
    for (int k = 0; k < 32; k++) begin
      w = base + 32'(k);
      exp_q.push_back(w[31:24]);
      exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int limit, input bit rnd, output int n);
    n = 0;
    while (state != st && n < limit) begin
      tick();
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
      n++;
    end
    tx_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int n;
    rst = 1'b1; cmd = '0; cmd_valid = 1'b0; halt = 1'b0; tx_ready = 1'b1;
    reg_base = 32'hA500_0000;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_state", 32'(state), 0);
    chk("rst_step", 32'(step), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_reg_sel", 32'(reg_sel), 0);
    chk("rst_cycle_count", cycle_count, 0);

    // Single step
    send_cmd(8'h73);
    chk("step_state", 32'(state), 2);
    chk("step_step", 32'(step), 1);
    chk("step_cmd_ready", 32'(cmd_ready), 0);
    tick();
    chk("step_back_state", 32'(state), 0);
    chk("step_back_step", 32'(step), 0);
    chk("step_count", cycle_count, 1);

    // Unknown byte consumed, stays IDLE
    send_cmd(8'h78);
    chk("unknown_state", 32'(state), 0);
    chk("unknown_step", 32'(step), 0);

    // Dump, no backpressure
    reg_base = 32'hA500_0000;
    push_dump(reg_base);
    bytes_seen = 0;
    send_cmd(8'h72);
    chk("dump_load_state", 32'(state), 3);
    chk("dump_load_sel", 32'(reg_sel), 0);
    wait_state(3'd0, 400, 1'b0, n);
    chk("dump_cycles", 32'(n), 160);
    chk("dump_bytes", 32'(bytes_seen), 128);
    chk("dump_q_empty", 32'(exp_q.size()), 0);
    chk("dump_count_kept", cycle_count, 1);

    // Dump with random backpressure; distinct bytes within each word
    reg_base = 32'h1234_5600;
    push_dump(reg_base);
    bytes_seen = 0;
    send_cmd(8'h72);
    wait_state(3'd0, 3000, 1'b1, n);
    chk("bp_state", 32'(state), 0);
    chk("bp_bytes", 32'(bytes_seen), 128);
    chk("bp_q_empty", 32'(exp_q.size()), 0);

    // Run to halt
    do_reset();
    send_cmd(8'h63);
    chk("run_cmd_ready", 32'(cmd_ready), 0);
    for (int i = 0; i < 10; i++) begin
      chk("run_step", 32'(step), 1);
      chk("run_state", 32'(state), 1);
      tick();
    end
    halt = 1'b1;
    chk("run_step_last", 32'(step), 1);
    tick();
    halt = 1'b0;
    chk("halt_state", 32'(state), 5);
    chk("halt_step", 32'(step), 0);
    chk("halt_count", cycle_count, 11);
    chk("halt_cmd_ready", 32'(cmd_ready), 1);

    // In HALTED: 's' and 'c' ignored, i_halt ignored, 'r' dumps and returns
    halt = 1'b1;
    send_cmd(8'h73);
    chk("halted_s_state", 32'(state), 5);
    chk("halted_s_step", 32'(step), 0);
    send_cmd(8'h63);
    chk("halted_c_state", 32'(state), 5);
    halt = 1'b0;
    reg_base = 32'h0102_0300;
    push_dump(reg_base);
    bytes_seen = 0;
    send_cmd(8'h72);
    chk("halted_dump_state", 32'(state), 3);
    wait_state(3'd5, 400, 1'b0, n);
    chk("halted_dump_cycles", 32'(n), 160);
    chk("halted_dump_bytes", 32'(bytes_seen), 128);
    chk("halted_count", cycle_count, 11);

    // Step with halt retiring goes to HALTED; halt ignored in IDLE
    do_reset();
    halt = 1'b1;
    tick();
    chk("idle_halt_ignored", 32'(state), 0);
    send_cmd(8'h73);
    chk("step_halt_state", 32'(state), 2);
    tick();
    halt = 1'b0;
    chk("step_halt_to_halted", 32'(state), 5);
    chk("step_halt_count", cycle_count, 1);

    // Mid-dump reset after 50 bytes
    do_reset();
    send_cmd(8'h73);
    tick();
    reg_base = 32'hA500_0000;
    push_dump(reg_base);
    bytes_seen = 0;
    send_cmd(8'h72);
    n = 0;
    while (bytes_seen < 50 && n < 400) begin
      tick();
      n++;
    end
    chk("mid_reached_50", 32'(bytes_seen), 50);
    rst = 1'b1;
    tx_ready = 1'b0;
    tick();
    rst = 1'b0;
    tx_ready = 1'b1;
    exp_q.delete();
    chk("mid_rst_state", 32'(state), 0);
    chk("mid_rst_tx_valid", 32'(tx_valid), 0);
    chk("mid_rst_count", cycle_count, 0);
    chk("mid_rst_sel", 32'(reg_sel), 0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 1);
    tick(); tick();
    chk("mid_no_more_bytes", 32'(bytes_seen), 50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debug_step_controller.md
DEBUG_STEP_CONTROLLER -- requirements
Module: debug_step_controller

Interface
REQ-001 The block SHALL have parameter NBITS, default 32, giving the register data width.
REQ-002 Clocking: one clock; reset is synchronous and active-high; ports i_clk and i_rst.
REQ-003 Port: i_clk  in  1  system clock; all state changes on its rising edge.
REQ-004 Port: i_rst  in  1  synchronous active-high reset.
REQ-005 Port: i_cmd  in  8  command byte from the host link.
REQ-006 Port: i_cmd_valid  in  1  i_cmd is valid this cycle.
REQ-007 Port: o_cmd_ready  out  1  command is accepted when i_cmd_valid and o_cmd_ready are both 1.
REQ-008 Port: i_halt  in  1  halt instruction has retired in the pipeline.
REQ-009 Port: i_dbg_reg_data  in  NBITS  register-file debug read data (combinational from o_dbg_reg_sel).
REQ-010 Port: o_dbg_reg_sel  out  5  register-file debug read index.
REQ-011 Port: o_step  out  1  pipeline advance enable, one pipeline cycle per high cycle.
REQ-012 Port: o_tx_data  out  8  byte to host link.
REQ-013 Port: o_tx_valid  out  1  o_tx_data is valid.
REQ-014 Port: i_tx_ready  in  1  host link accepts o_tx_data when o_tx_valid is also 1.
REQ-015 Port: o_cycle_count  out  32  count of cycles with o_step=1.
REQ-016 Port: o_state  out  3  current FSM state encoding.

Function
REQ-017 The FSM SHALL have states IDLE=0, RUN=1, STEP=2, DUMP_LOAD=3, DUMP_SEND=4, HALTED=5.
REQ-018 o_cmd_ready SHALL be 1 only in IDLE and HALTED.
REQ-019 In IDLE, an accepted command SHALL map as follows: 0x63 'c' goes to RUN; 0x73 's' goes to STEP; 0x72 'r' goes to DUMP_LOAD with return target IDLE; any other byte is consumed and the FSM stays in IDLE.
REQ-020 o_step SHALL be a Moore output equal to 1 exactly when the state is RUN or STEP.
REQ-021 In RUN, i_halt=1 SHALL move the FSM to HALTED on the next edge. Otherwise it stays in RUN. Commands are not accepted in RUN.
REQ-022 STEP SHALL last exactly one cycle. It then goes to HALTED if i_halt=1 in that cycle, else to IDLE.
REQ-023 In HALTED, o_step SHALL be 0. Only 'r' is acted on, going to DUMP_LOAD with return target HALTED. Other bytes are consumed and ignored. Only i_rst leaves HALTED.
REQ-024 Dump sequencing uses a 5-bit reg_idx and a 2-bit byte_idx. Both are cleared on entry to DUMP_LOAD from IDLE or HALTED.
REQ-025 DUMP_LOAD SHALL last one cycle with o_dbg_reg_sel=reg_idx. In that cycle it captures i_dbg_reg_data into a 32-bit buffer, then goes to DUMP_SEND.
REQ-026 In DUMP_SEND, o_tx_valid SHALL be 1 and o_tx_data SHALL be buffer byte byte_idx, MSB first (byte_idx 0 = bits 31:24).
REQ-027 o_tx_data SHALL stay stable while o_tx_valid=1 and i_tx_ready=0.
REQ-028 On each accepted byte, byte_idx SHALL increment. After byte_idx 3 is accepted: if reg_idx<31, reg_idx increments and the FSM goes to DUMP_LOAD; if reg_idx=31, the FSM goes to the return target.
REQ-029 A full dump SHALL send exactly 128 bytes (32 registers x 4).
REQ-030 With i_tx_ready held at 1, a full dump SHALL take 160 cycles (32 x (1 load + 4 send)).
REQ-031 o_tx_valid SHALL be 0 in every state other than DUMP_SEND.
REQ-032 o_dbg_reg_sel SHALL hold reg_idx in DUMP_LOAD and DUMP_SEND, and be 0 otherwise.
REQ-033 o_cycle_count SHALL increment by 1 on every edge where o_step=1. It saturates at 0xFFFFFFFF and is never cleared except by i_rst.
REQ-034 i_halt SHALL be ignored in IDLE, DUMP_LOAD, DUMP_SEND and HALTED.
REQ-035 i_cmd_valid arriving while o_cmd_ready=0 SHALL not be consumed; the host holds it.

Reset
REQ-036 When i_rst=1 at an edge, the next state SHALL be: state IDLE, o_step 0, o_cmd_ready 1, o_tx_valid 0, o_tx_data 0x00, o_dbg_reg_sel 0, o_cycle_count 0, o_state 0, buffer 0, reg_idx 0, byte_idx 0, return target IDLE.
REQ-037 Reset SHALL take priority over every transition, including mid-dump and in HALTED, and SHALL abort any byte in flight.

Verification
REQ-038 Step scenario: from IDLE send 's' with i_halt=0 -> o_step high for exactly 1 cycle, o_cycle_count=1, state returns to IDLE.
REQ-039 Run-to-halt scenario: send 'c', assert i_halt 10 cycles later -> o_step high for 11 cycles, then state HALTED, o_cycle_count=11, o_cmd_ready=1.
REQ-040 Dump with no backpressure: preload reg k = 0xA5000000+k, send 'r' with i_tx_ready=1 -> 128 bytes A5,00,00,00, A5,00,00,01, ... A5,00,00,1F in 160 cycles, then state IDLE.
REQ-041 Backpressure scenario: during a dump, toggle i_tx_ready randomly -> no byte is dropped or duplicated, and o_tx_data stays stable while stalled.
REQ-042 Halted-dump scenario: in HALTED send 's', then 'r' -> 's' has no effect (o_step stays 0), the dump completes, and the state returns to HALTED.
REQ-043 Mid-dump reset: assert i_rst after 50 bytes -> next cycle the state is IDLE, o_tx_valid=0 and o_cycle_count=0.
